// File: rtl/alu_writeback_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_stage_if
//  Description : Bus bundle between the ALU result producer, the writeback
//                stage and the register file (result input, writeback head,
//                forwarding query, architectural flags).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_writeback_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   // Result input side
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] aluOut;
   logic                  zero;
   logic [ADDR_WIDTH-1:0] rdAddr;
   logic                  regWrite;
   logic                  flagWrite;
   logic                  flush;
   // Writeback head
   logic                  wb_valid;
   logic                  wb_ready;
   logic [DATA_WIDTH-1:0] wb_data;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic                  wb_regWrite;
   // Forwarding lookup
   logic [ADDR_WIDTH-1:0] fwdAddr;
   logic                  fwdHit;
   logic [DATA_WIDTH-1:0] fwdData;
   // Architectural state
   logic                  flagZero;
   logic                  flagNeg;
   logic [31:0]           retireCount;

   // Environment side: drives results, ready and queries
   modport master (
      output in_valid, aluOut, zero, rdAddr, regWrite, flagWrite, flush,
             wb_ready, fwdAddr,
      input  in_ready, wb_valid, wb_data, wb_addr, wb_regWrite, fwdHit,
             fwdData, flagZero, flagNeg, retireCount
   );

   // Stage side
   modport slave (
      input  in_valid, aluOut, zero, rdAddr, regWrite, flagWrite, flush,
             wb_ready, fwdAddr,
      output in_ready, wb_valid, wb_data, wb_addr, wb_regWrite, fwdHit,
             fwdData, flagZero, flagNeg, retireCount
   );
endinterface
`default_nettype wire

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_stage
//  Description : Execute-to-writeback stage. Two-entry result FIFO with a
//                registered in_ready, valid/ready writeback head, newest-wins
//                forwarding lookup and retirement-time condition flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   alu_writeback_stage_if.slave      bus
);
   // Entry storage, indexed by the 1-bit head/tail pointers
   logic [DATA_WIDTH-1:0] data_q [2];
   logic [ADDR_WIDTH-1:0] addr_q [2];
   logic [1:0]            zero_q;
   logic [1:0]            regw_q;
   logic [1:0]            flagw_q;

   logic                  head_q;
   logic                  tail_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;
   logic                  in_ready_q;
   logic                  in_ready_d;
   logic                  flag_zero_q;
   logic                  flag_neg_q;
   logic [31:0]           retire_cnt_q;

   logic                  enq;
   logic                  deq;
   logic                  head_valid;
   logic                  newest;
   logic                  fwd_hit;
   logic [DATA_WIDTH-1:0] fwd_data;

   assign head_valid = (count_q != 2'd0);
   assign enq        = bus.in_valid & in_ready_q;
   assign deq        = head_valid & bus.wb_ready;
   assign newest     = ~tail_q;

   // Next occupancy; in_ready is a register derived from it so wb_ready never
   // reaches in_ready combinationally.
   always_comb begin
      count_d = count_q;
      if (bus.flush) begin
         count_d = 2'd0;
      end else if (enq && !deq) begin
         count_d = count_q + 2'd1;
      end else if (deq && !enq) begin
         count_d = count_q - 2'd1;
      end
      in_ready_d = (count_d != 2'd2);
   end

   // Buffer, pointers, flags and retire counter; flush overrides enq/deq
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q[0]    <= '0;
         data_q[1]    <= '0;
         addr_q[0]    <= '0;
         addr_q[1]    <= '0;
         zero_q       <= '0;
         regw_q       <= '0;
         flagw_q      <= '0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         count_q      <= 2'd0;
         in_ready_q   <= 1'b1;
         flag_zero_q  <= 1'b0;
         flag_neg_q   <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
         if (bus.flush) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
         end else begin
            if (enq) begin
               data_q[tail_q]  <= bus.aluOut;
               addr_q[tail_q]  <= bus.rdAddr;
               zero_q[tail_q]  <= bus.zero;
               regw_q[tail_q]  <= bus.regWrite;
               flagw_q[tail_q] <= bus.flagWrite;
               tail_q          <= ~tail_q;
            end
            if (deq) begin
               head_q       <= ~head_q;
               retire_cnt_q <= retire_cnt_q + 32'd1;
               if (flagw_q[head_q]) begin
                  flag_zero_q <= zero_q[head_q];
                  flag_neg_q  <= data_q[head_q][DATA_WIDTH-1];
               end
            end
         end
      end
   end

   // Forwarding search: newest entry first, older entry only when both valid
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (bus.fwdAddr != '0) begin
         if (head_valid && regw_q[newest] && (addr_q[newest] == bus.fwdAddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[newest];
         end else if ((count_q == 2'd2) && regw_q[head_q] &&
                      (addr_q[head_q] == bus.fwdAddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[head_q];
         end
      end
   end

   // Head outputs read as zero whenever the buffer is empty
   assign bus.in_ready    = in_ready_q;
   assign bus.wb_valid    = head_valid;
   assign bus.wb_data     = head_valid ? data_q[head_q] : '0;
   assign bus.wb_addr     = head_valid ? addr_q[head_q] : '0;
   assign bus.wb_regWrite = head_valid & regw_q[head_q] & (addr_q[head_q] != '0);
   assign bus.fwdHit      = fwd_hit;
   assign bus.fwdData     = fwd_data;
   assign bus.flagZero    = flag_zero_q;
   assign bus.flagNeg     = flag_neg_q;
   assign bus.retireCount = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_writeback_stage
//  Description : Cycle-table bench for alu_writeback_stage. Each row gives the
//                inputs for one cycle and the outputs expected during that
//                cycle, before the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback_stage;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   alu_writeback_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   alu_writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        z;
      logic [4:0]  rd;
      logic        rw;
      logic        fw;
      logic        fl;
      logic        wr;
      logic [4:0]  fa;
      logic        e_ir;
      logic        e_v;
      logic [31:0] e_d;
      logic [4:0]  e_a;
      logic        e_rw;
      logic        e_fh;
      logic [31:0] e_fd;
      logic        e_fz;
      logic        e_fn;
      logic [31:0] e_rc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic [31:0] iv, d, z, rd, rw, fw, fl, wr, fa,
      input logic [31:0] e_ir, e_v, e_d, e_a, e_rw, e_fh, e_fd, e_fz, e_fn, e_rc);
      vec_t r;
      r.iv = iv[0];    r.d  = d;        r.z  = z[0];     r.rd = rd[4:0];
      r.rw = rw[0];    r.fw = fw[0];    r.fl = fl[0];    r.wr = wr[0];
      r.fa = fa[4:0];  r.e_ir = e_ir[0]; r.e_v = e_v[0]; r.e_d = e_d;
      r.e_a = e_a[4:0]; r.e_rw = e_rw[0]; r.e_fh = e_fh[0]; r.e_fd = e_fd;
      r.e_fz = e_fz[0]; r.e_fn = e_fn[0]; r.e_rc = e_rc;
      return r;
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.in_valid = 1'b0; bus.aluOut = '0; bus.zero = 1'b0; bus.rdAddr = '0;
      bus.regWrite = 1'b0; bus.flagWrite = 1'b0; bus.flush = 1'b0;
      bus.wb_ready = 1'b0; bus.fwdAddr = '0;
   endtask

   task automatic check_reset_values(input int row);
      chk("rst_in_ready", row, 32'(bus.in_ready), 32'd1);
      chk("rst_wb_valid", row, 32'(bus.wb_valid), 32'd0);
      chk("rst_wb_data", row, bus.wb_data, 32'd0);
      chk("rst_wb_addr", row, 32'(bus.wb_addr), 32'd0);
      chk("rst_wb_regWrite", row, 32'(bus.wb_regWrite), 32'd0);
      chk("rst_fwdHit", row, 32'(bus.fwdHit), 32'd0);
      chk("rst_fwdData", row, bus.fwdData, 32'd0);
      chk("rst_flagZero", row, 32'(bus.flagZero), 32'd0);
      chk("rst_flagNeg", row, 32'(bus.flagNeg), 32'd0);
      chk("rst_retireCount", row, bus.retireCount, 32'd0);
   endtask

   task automatic apply_row(input int i);
      vec_t r;
      r = vq[i];
      @(negedge clk);
      bus.in_valid = r.iv;  bus.aluOut = r.d;     bus.zero = r.z;
      bus.rdAddr = r.rd;    bus.regWrite = r.rw;  bus.flagWrite = r.fw;
      bus.flush = r.fl;     bus.wb_ready = r.wr;  bus.fwdAddr = r.fa;
      #1;
      chk("in_ready", i, 32'(bus.in_ready), 32'(r.e_ir));
      chk("wb_valid", i, 32'(bus.wb_valid), 32'(r.e_v));
      chk("wb_data", i, bus.wb_data, r.e_d);
      chk("wb_addr", i, 32'(bus.wb_addr), 32'(r.e_a));
      chk("wb_regWrite", i, 32'(bus.wb_regWrite), 32'(r.e_rw));
      chk("fwdHit", i, 32'(bus.fwdHit), 32'(r.e_fh));
      chk("fwdData", i, bus.fwdData, r.e_fd);
      chk("flagZero", i, 32'(bus.flagZero), 32'(r.e_fz));
      chk("flagNeg", i, 32'(bus.flagNeg), 32'(r.e_fn));
      chk("retireCount", i, bus.retireCount, r.e_rc);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      //          iv d            z rd rw fw fl wr fa | ir v  data        a  rw fh fd      fz fn rc
      // single write, retire
      vq.push_back(mk(1, 'h2A,        0, 3, 1, 1, 0, 1, 0,  1, 0, 0,          0, 0, 0, 0,     0, 0, 0));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 3,  1, 1, 'h2A,       3, 1, 1, 'h2A,  0, 0, 0));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 3,  1, 0, 0,          0, 0, 0, 0,     0, 0, 1));
      // backpressure: fill, reject 0x33, drain in order
      vq.push_back(mk(1, 'h11,        0, 1, 1, 0, 0, 0, 0,  1, 0, 0,          0, 0, 0, 0,     0, 0, 1));
      vq.push_back(mk(1, 'h22,        0, 2, 1, 0, 0, 0, 1,  1, 1, 'h11,       1, 1, 1, 'h11,  0, 0, 1));
      vq.push_back(mk(1, 'h33,        0, 3, 1, 0, 0, 0, 2,  0, 1, 'h11,       1, 1, 1, 'h22,  0, 0, 1));
      vq.push_back(mk(1, 'h33,        0, 3, 1, 0, 0, 1, 3,  0, 1, 'h11,       1, 1, 0, 0,     0, 0, 1));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 0,  1, 1, 'h22,       2, 1, 0, 0,     0, 0, 2));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 0, 0,  1, 0, 0,          0, 0, 0, 0,     0, 0, 3));
      // flags: update on retire only, hold when flagWrite=0
      vq.push_back(mk(1, 'h80000000,  0, 4, 1, 1, 0, 1, 0,  1, 0, 0,          0, 0, 0, 0,     0, 0, 3));
      vq.push_back(mk(1, 0,           1, 6, 1, 0, 0, 1, 0,  1, 1, 'h80000000, 4, 1, 0, 0,     0, 0, 3));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 0,  1, 1, 0,          6, 1, 0, 0,     0, 1, 4));
      vq.push_back(mk(1, 0,           1, 7, 1, 1, 0, 1, 0,  1, 0, 0,          0, 0, 0, 0,     0, 1, 5));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 0,  1, 1, 0,          7, 1, 0, 0,     0, 1, 5));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 0, 0,  1, 0, 0,          0, 0, 0, 0,     1, 0, 6));
      // forwarding: newest r5 wins, r0 never hits and retires without write
      vq.push_back(mk(1, 'h10,        0, 5, 1, 0, 0, 0, 5,  1, 0, 0,          0, 0, 0, 0,     1, 0, 6));
      vq.push_back(mk(1, 'h20,        0, 5, 1, 0, 0, 0, 5,  1, 1, 'h10,       5, 1, 1, 'h10,  1, 0, 6));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 0, 5,  0, 1, 'h10,       5, 1, 1, 'h20,  1, 0, 6));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 5,  0, 1, 'h10,       5, 1, 1, 'h20,  1, 0, 6));
      vq.push_back(mk(1, 'h55,        0, 0, 1, 0, 0, 0, 5,  1, 1, 'h20,       5, 1, 1, 'h20,  1, 0, 7));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 0, 0,  0, 1, 'h20,       5, 1, 0, 0,     1, 0, 7));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 5,  0, 1, 'h20,       5, 1, 1, 'h20,  1, 0, 7));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 0, 0,  1, 1, 'h55,       0, 0, 0, 0,     1, 0, 8));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 0,  1, 1, 'h55,       0, 0, 0, 0,     1, 0, 8));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 0, 0,  1, 0, 0,          0, 0, 0, 0,     1, 0, 9));
      // flush with wb_ready=1 and in_valid=1: nothing retires or enters
      vq.push_back(mk(1, 'hAA,        0, 8, 1, 1, 0, 0, 0,  1, 0, 0,          0, 0, 0, 0,     1, 0, 9));
      vq.push_back(mk(1, 0,           1, 9, 1, 1, 0, 0, 0,  1, 1, 'hAA,       8, 1, 0, 0,     1, 0, 9));
      vq.push_back(mk(1, 'hBB,        0, 10, 1, 1, 1, 1, 8, 0, 1, 'hAA,       8, 1, 1, 'hAA,  1, 0, 9));
      vq.push_back(mk(0, 0,           0, 0, 0, 0, 0, 1, 8,  1, 0, 0,          0, 0, 0, 0,     1, 0, 9));

      drive_idle();
      rst_n = 1'b0;
      #12;
      check_reset_values(-1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) apply_row(i);

      // Asynchronous reset mid-cycle with two entries pending
      @(negedge clk);
      bus.in_valid = 1'b1; bus.aluOut = 32'h66; bus.rdAddr = 5'd12;
      bus.regWrite = 1'b1; bus.flagWrite = 1'b1; bus.zero = 1'b0;
      bus.flush = 1'b0; bus.wb_ready = 1'b0; bus.fwdAddr = 5'd12;
      @(negedge clk);
      bus.aluOut = 32'h77; bus.rdAddr = 5'd13;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk("pre_rst_wb_valid", 100, 32'(bus.wb_valid), 32'd1);
      chk("pre_rst_in_ready", 100, 32'(bus.in_ready), 32'd0);
      chk("pre_rst_fwdHit", 100, 32'(bus.fwdHit), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values(101);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) apply_row(i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
